// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes and sweep FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte-write mask and replicated store data for stores,
// lane extraction with sign/zero extension for loads, and the misalignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        uns,
    input  logic [31:0] wd,
    input  logic [31:0] raw_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign misalign = ((size == SZ_HALF) && lane[0])
                    || ((size == SZ_WORD) && (lane != 2'b00))
                    || (size == SZ_RSVD);

    assign byte_sel = raw_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        be     = 4'b0000;
        wdata  = wd;
        rd_ext = 32'h0;
        case (size)
            SZ_BYTE: begin
                be     = 4'b0001 << lane;
                wdata  = {4{wd[7:0]}};
                rd_ext = {{24{byte_sel[7] & ~uns}}, byte_sel};
            end
            SZ_HALF: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{wd[15:0]}};
                rd_ext = {{16{half_sel[15] & ~uns}}, half_sel};
            end
            SZ_WORD: begin
                be     = 4'b1111;
                wdata  = wd;
                rd_ext = raw_word;
            end
            default: begin
                be     = 4'b0000;
                wdata  = wd;
                rd_ext = 32'h0;
            end
        endcase
        // A misaligned access never names a legal lane set.
        if (misalign) begin
            be = 4'b0000;
        end
    end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable data memory with a post-reset clearing sweep.
// Define DMEM_READ_REG_EN to register RD for one-cycle load latency.
module data_memory_be
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int TST_WORD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] RD,
    output logic        busy,
    output logic        misalign,
    output logic        oob,
    output logic [15:0] tst
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] TST_IDX  = AW'(TST_WORD);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [31:0]   mem [DEPTH];
    dmem_state_e   state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rd_ext;
    logic          store_en;
    logic          rd_kill;

    assign idx      = A[AW+1:2];
    assign oob      = (A[31:2] >= 30'(DEPTH));
    assign busy     = (state == ST_INIT);
    assign store_en = WE && !busy && !misalign && !oob;
    assign rd_kill  = busy || misalign || oob;
    assign tst      = mem[TST_IDX][15:0];

    dmem_lane_align u_lane_align (
        .size     (size),
        .lane     (A[1:0]),
        .uns      (uns),
        .wd       (WD),
        .raw_word (mem[idx]),
        .be       (be),
        .wdata    (wdata),
        .rd_ext   (rd_ext),
        .misalign (misalign)
    );

    // Sweep FSM: one word per cycle from ptr=0, exactly DEPTH cycles in INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == LAST_IDX) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Contents carry no reset; only the sweep or a qualified store changes them.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[ptr] <= 32'h0;
        end else if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

`ifdef DMEM_READ_REG_EN
    // Captures the pre-write word, so read-during-write returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RD <= 32'h0;
        end else begin
            RD <= rd_kill ? 32'h0 : rd_ext;
        end
    end
`else
    assign RD = rd_kill ? 32'h0 : rd_ext;
`endif

endmodule

// File: tb/tb_data_memory_be.sv
// Directed, table-driven bench for data_memory_be (DEPTH=256, TST_WORD=0).
module tb_data_memory_be;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rd;
    logic        busy;
    logic        misalign;
    logic        oob;
    logic [15:0] tst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_oob;
    } vec_t;

    vec_t vecs[$];

    data_memory_be #(.DEPTH(DEPTH), .TST_WORD(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a),
        .WD       (wd),
        .WE       (we),
        .size     (size),
        .uns      (uns),
        .RD       (rd),
        .busy     (busy),
        .misalign (misalign),
        .oob      (oob),
        .tst      (tst)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] va, input logic [31:0] vwd, input logic vwe,
                       input logic [1:0] vsz, input logic vuns, input logic [31:0] vrd,
                       input logic vmis, input logic voob);
        vec_t v;
        v.a = va; v.wd = vwd; v.we = vwe; v.sz = vsz; v.uns = vuns;
        v.exp_rd = vrd; v.exp_mis = vmis; v.exp_oob = voob;
        vecs.push_back(v);
    endtask

    initial begin
        int cnt;

        // Stores carry exp_rd = pre-write data (old word before the edge).
        add(32'h8, 32'h80FF_7F01, 1, 2'b10, 0, 32'h0000_0000, 0, 0);
        add(32'h8, 32'h0,         0, 2'b10, 0, 32'h80FF_7F01, 0, 0);
        add(32'h8, 32'h0,         0, 2'b00, 0, 32'h0000_0001, 0, 0);
        add(32'hB, 32'h0,         0, 2'b00, 0, 32'hFFFF_FF80, 0, 0);
        add(32'hB, 32'h0,         0, 2'b00, 1, 32'h0000_0080, 0, 0);
        add(32'hA, 32'h0,         0, 2'b01, 0, 32'hFFFF_80FF, 0, 0);
        add(32'hA, 32'h0,         0, 2'b01, 1, 32'h0000_80FF, 0, 0);
        add(32'h8, 32'h0,         0, 2'b01, 0, 32'h0000_7F01, 0, 0);
        add(32'h9, 32'h1234_56AA, 1, 2'b00, 0, 32'h0000_007F, 0, 0);
        add(32'h8, 32'h0,         0, 2'b10, 0, 32'h80FF_AA01, 0, 0);
        add(32'h5, 32'h0000_FFFF, 1, 2'b01, 0, 32'h0000_0000, 1, 0);
        add(32'h6, 32'hFFFF_FFFF, 1, 2'b10, 0, 32'h0000_0000, 1, 0);
        add(32'h8, 32'hFFFF_FFFF, 1, 2'b11, 0, 32'h0000_0000, 1, 0);
        add(32'h8, 32'h0,         0, 2'b10, 0, 32'h80FF_AA01, 0, 0);
        add(32'h4, 32'h0,         0, 2'b10, 0, 32'h0000_0000, 0, 0);
        add(32'h400, 32'hDEAD_BEEF, 1, 2'b10, 0, 32'h0000_0000, 0, 1);
        add(32'h0, 32'h0,         0, 2'b10, 0, 32'h0000_0000, 0, 0);
        add(32'hFFFF_FFFC, 32'h0, 0, 2'b10, 0, 32'h0000_0000, 0, 1);
        add(32'hE, 32'h0000_BEEF, 1, 2'b01, 0, 32'h0000_0000, 0, 0);
        add(32'hE, 32'h0,         0, 2'b01, 1, 32'h0000_BEEF, 0, 0);
        add(32'hE, 32'h0,         0, 2'b01, 0, 32'hFFFF_BEEF, 0, 0);
        add(32'hC, 32'h0,         0, 2'b01, 0, 32'h0000_0000, 0, 0);
        add(32'hC, 32'h0,         0, 2'b10, 0, 32'hBEEF_0000, 0, 0);
        add(32'h8, 32'h1111_2222, 1, 2'b10, 0, 32'h80FF_AA01, 0, 0);
        add(32'h8, 32'h0,         0, 2'b10, 0, 32'h1111_2222, 0, 0);
        add(32'h0, 32'h1234_5678, 1, 2'b10, 0, 32'h0000_0000, 0, 0);
        add(32'h0, 32'h0,         0, 2'b10, 0, 32'h1234_5678, 0, 0);

        // Reset state
        rst = 1'b1; a = 32'h400; wd = 32'h0; we = 1'b0; size = 2'b11; uns = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_rd", rd, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h1);
        check("rst_oob", {31'h0, oob}, 32'h1);

        // Start a sweep, then restart it mid-way at cycle 10
        a = 32'h0; size = 2'b10;
        @(negedge clk) rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("midreset_busy", {31'h0, busy}, 32'h1);
        @(negedge clk) rst = 1'b1;

        // Count busy cycles after release; a store to word 4 at cycle 20 must drop
        cnt = 0;
        while (busy && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 20) begin
                a = 32'h10; wd = 32'hDEAD_BEEF; size = 2'b10; we = 1'b1;
            end
            if (cnt == 21) begin
                check("busy_rd_zero", rd, 32'h0);
                we = 1'b0; a = 32'h0;
            end
        end
        check("sweep_cycles", cnt, 32'd256);
        check("tst_after_sweep", {16'h0, tst}, 32'h0);
        a = 32'h10; size = 2'b10; we = 1'b0;
        #1 check("busy_store_dropped", rd, 32'h0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a = vecs[i].a; wd = vecs[i].wd; we = vecs[i].we;
            size = vecs[i].sz; uns = vecs[i].uns;
            #1;
            check($sformatf("vec%0d_mis", i), {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
            check($sformatf("vec%0d_oob", i), {31'h0, oob}, {31'h0, vecs[i].exp_oob});
`ifndef DMEM_READ_REG_EN
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
`endif
            @(posedge clk);
            #1;
`ifdef DMEM_READ_REG_EN
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
`endif
        end

        // Debug halfword reflects the last store to word 0
        @(negedge clk);
        we = 1'b0;
        check("tst_after_store", {16'h0, tst}, 32'h0000_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
- Parametrised byte-addressable data memory for the single-cycle MIPS datapath; the successor to the fixed 100-word word-only RAM.
- Adds byte/halfword/word stores and loads with sign or zero extension, misalignment and out-of-range detection, and a configurable depth.
- Clears itself after reset with a one-word-per-cycle sweep FSM and flags `busy` while the sweep runs, instead of clearing every word in one cycle.
- Sits between the ALU result / rt operand and the write-back mux; `tst` exposes a debug halfword to the board display.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, minimum 4.
- TST_WORD, 0, word index mirrored on `tst`.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- A  in  32  byte address from the ALU.
- WD  in  32  store data; the low bits are used for byte/half stores.
- WE  in  1  store request.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- uns  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend.
- RD  out  32  load data, already extended.
- busy  out  1  init sweep in progress.
- misalign  out  1  current access is misaligned, or `size` is 11.
- oob  out  1  word index A[31:2] >= DEPTH.
- tst  out  16  mem[TST_WORD][15:0].

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, on ports `clk` and `rst`.
- Word index and lane: idx = A[log2(DEPTH)+1:2]; lane = A[1:0]; little-endian, byte 0 = bits [7:0].
- FSM states: INIT, IDLE.
- rst low: state=INIT, ptr=0, busy=1, asynchronously.
- INIT, each rising edge:
  - mem[ptr] <= 0 and ptr <= ptr+1.
  - When ptr == DEPTH-1 and that word is cleared, go to IDLE; busy=0 from the next cycle.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
- IDLE: stays IDLE until rst is asserted again. Reset mid-sweep restarts from ptr=0.
- Memory contents are not reset by rst directly; only the sweep clears them.
- Misalignment: misalign = (size==01 & A[0]) | (size==10 & A[1:0]!=0) | (size==11). It is combinational and asserted regardless of WE.
- Out of range: oob = (A[31:2] >= DEPTH), combinational.
- Store (commits at the rising edge) requires WE & !busy & !misalign & !oob.
  - Byte: writes only lane A[1:0] with WD[7:0].
  - Half: writes lanes {A[1],0} and {A[1],1} with WD[15:0].
  - Word: writes all lanes with WD.
  - Unselected lanes are preserved.
  - A suppressed store has no effect on any word.
- Load is combinational from A: zero latency, RD valid in the same cycle.
  - Byte: extract lane A[1:0]; sign-extend bit 7 unless `uns`.
  - Half: extract the selected halfword; sign-extend bit 15 unless `uns`.
  - Word: full word; `uns` ignored.
- RD = 0 when busy, misalign or oob.
- Read-during-write to the same word: RD shows the old data until the edge, then the new data.
- tst = mem[TST_WORD][15:0], combinational. It reads 0 during and after the sweep until that word is written.
- Reset values: busy=1; RD=0, since busy forces it; misalign and oob follow A/size combinationally; tst=0 once swept.

Optional Feature:
- DMEM_READ_REG_EN defined:
  - RD becomes a register updated at each rising edge from the current A/size/uns, giving one-cycle load latency for a pipelined core.
  - A read-during-write returns the pre-write data.
  - The RD register resets asynchronously to 0 and holds 0 while busy.
- DMEM_READ_REG_EN undefined: RD is combinational as described above.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encodings ST_INIT, ST_IDLE.
- One sub-module, dmem_lane_align (combinational):
  - Inputs: size, lane, uns, WD, raw word.
  - Outputs: 4-bit byte-write mask, lane-shifted write data, extended load data, misalign.
- The top holds the RAM array, the sweep FSM, ptr, oob, and the optional read register.

Test Plan:
- Pulse rst low mid-sweep at cycle 10 (DEPTH=256) -> ptr restarts; busy stays 1 for exactly 256 cycles after release. A word store issued while busy is dropped, and that word reads 0 afterwards.
- After init: sw A=0x8 WD=0x80FF_7F01; then lb A=0x8 -> 0x0000_0001; lb A=0xB -> 0xFFFF_FF80; lbu A=0xB -> 0x0000_0080; lh A=0xA -> 0xFFFF_80FF; lhu A=0xA -> 0x0000_80FF.
- sb A=0x9 WD=0xAA on word 0x8 above -> lw A=0x8 = 0x80FF_AA01; the other lanes are unchanged.
- sh A=0x5 and sw A=0x6 -> misalign=1, no write, RD=0. size=11 -> misalign=1.
- A=4*DEPTH with WE=1 -> oob=1, no write, RD=0; word 0 is not aliased and stays unchanged.
- sw A=4*TST_WORD WD=0x1234_5678 -> tst=0x5678 in the following cycle. With DMEM_READ_REG_EN, lw of that word shows RD one cycle after A is applied.
